// File: rtl/regfile_sseg_scan_if.sv
// Bus bundle for regfile_sseg_scan: register-bank access signals from the
// board switches/buttons plus the seven-segment/anode pins.
// master: switch/button side; slave: the register bank/display block.
interface regfile_sseg_scan_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int NUM_RD = 2
);
  localparam int NUM_DIG = NUM_RD * DATA_W / 4;

  logic [NUM_RD*ADDR_W-1:0] readAddr;
  logic [ADDR_W-1:0]        writeAddr1;
  logic [DATA_W-1:0]        data;
  logic                     rwrite;
  logic [6:0]               sseg;
  logic [NUM_DIG-1:0]       an;

  modport master (
    output readAddr,
    output writeAddr1,
    output data,
    output rwrite,
    input  sseg,
    input  an
  );

  modport slave (
    input  readAddr,
    input  writeAddr1,
    input  data,
    input  rwrite,
    output sseg,
    output an
  );
endinterface

// File: rtl/regfile_sseg_scan.sv
// regfile_sseg_scan: register bank (one write port, NUM_RD read ports) whose
// read values are shown in hex on a time-multiplexed common-anode
// seven-segment display. Digit d shows nibble (d mod DATA_W/4) of read
// port d/(DATA_W/4); digit 0 is the low nibble of port 0.
// Optional build macro RFSS_WR_BYPASS_EN: read-during-write bypass, so a
// read port addressing the register being written sees the write data in
// the same cycle.
module regfile_sseg_scan #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 4,
  parameter int NUM_RD      = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sseg_scan_if.slave  bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NPD     = DATA_W / 4;
  localparam int NUM_DIG = NUM_RD * NPD;
  localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_flat;
  logic [CNT_W-1:0]         cnt;
  logic                     tick;
  logic [DIG_W-1:0]         dig;
  logic [3:0]               cur_nib;
  logic [NUM_DIG-1:0]       an_q;
  logic [6:0]               sseg_q;

  // Active-low gfedcba hex glyphs.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Register array: reset loads each entry with its own index, writes on rwrite low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (!bus.rwrite) begin
      regs[bus.writeAddr1] <= bus.data;
    end
  end

  // Read ports, packed so that nibble d of rd_flat is display digit d.
  always_comb begin
    rd_flat = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_flat[k*DATA_W +: DATA_W] = regs[bus.readAddr[k*ADDR_W +: ADDR_W]];
`ifdef RFSS_WR_BYPASS_EN
      if (!bus.rwrite && (bus.readAddr[k*ADDR_W +: ADDR_W] == bus.writeAddr1)) begin
        rd_flat[k*DATA_W +: DATA_W] = bus.data;
      end
`endif
    end
  end

  // Nibble for the digit the index currently points at.
  always_comb begin
    cur_nib = '0;
    for (int unsigned d = 0; d < NUM_DIG; d++) begin
      if (dig == DIG_W'(d)) begin
        cur_nib = rd_flat[d*4 +: 4];
      end
    end
  end

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Slot timer: one tick every REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index names the digit shown at the next tick, so the first
  // tick after reset drives digit 0 and then steps the index on.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig <= '0;
    end else if (tick) begin
      if (dig == DIG_W'(NUM_DIG - 1)) begin
        dig <= '0;
      end else begin
        dig <= dig + 1'b1;
      end
    end
  end

  // Registered pins, updated only on a tick so a slot never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '1;
      sseg_q <= '1;
    end else if (tick) begin
      an_q   <= ~(NUM_DIG'(1) << dig);
      sseg_q <= hex7(cur_nib);
    end
  end

  assign bus.an   = an_q;
  assign bus.sseg = sseg_q;

endmodule

// File: tb/tb_regfile_sseg_scan.sv
// Directed bench for regfile_sseg_scan: 8x4-bit/2-port instance and an
// 8x8-bit/2-port instance, both with a 4-cycle digit slot.
module tb_regfile_sseg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sseg_scan_if #(.ADDR_W(3), .DATA_W(4), .NUM_RD(2)) bus1 ();
  regfile_sseg_scan_if #(.ADDR_W(3), .DATA_W(8), .NUM_RD(2)) bus2 ();

  regfile_sseg_scan #(.ADDR_W(3), .DATA_W(4), .NUM_RD(2), .REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  regfile_sseg_scan #(.ADDR_W(3), .DATA_W(8), .NUM_RD(2), .REFRESH_DIV(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus1.readAddr = {3'd2, 3'd1};
    rst = 1'b1;
    steps(2);
    checks++;
    if (bus1.an !== 2'b11) begin failures++; $display("FAIL reset_an got=%b exp=%b", bus1.an, 2'b11); end
    checks++;
    if (bus1.sseg !== 7'h7F) begin failures++; $display("FAIL reset_sseg got=%b exp=%b", bus1.sseg, 7'h7F); end
    checks++;
    if (bus2.an !== 4'hF) begin failures++; $display("FAIL reset_an_wide got=%b exp=%b", bus2.an, 4'hF); end
    rst = 1'b0;
    steps(3);
    checks++;
    if (bus1.an !== 2'b11) begin failures++; $display("FAIL pre_tick_blank got=%b exp=%b", bus1.an, 2'b11); end
    step();
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b1111001) begin
      failures++; $display("FAIL first_tick got=%b/%b exp=10/1111001", bus1.an, bus1.sseg);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b01 || bus1.sseg !== 7'b0100100) begin
      failures++; $display("FAIL second_tick got=%b/%b exp=01/0100100", bus1.an, bus1.sseg);
    end
  endtask

  task automatic test_write();
    bus1.readAddr = {3'd2, 3'd1};
    do_reset();
    bus1.rwrite = 1'b0; bus1.writeAddr1 = 3'd1; bus1.data = 4'd4;
    step();
    bus1.writeAddr1 = 3'd2; bus1.data = 4'd5;
    step();
    bus1.rwrite = 1'b1;
    steps(2);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b0011001) begin
      failures++; $display("FAIL write_port0 got=%b/%b exp=10/0011001", bus1.an, bus1.sseg);
    end
    bus1.rwrite = 1'b0; bus1.writeAddr1 = 3'd1; bus1.data = 4'd9;
    step();
    bus1.rwrite = 1'b1;
    steps(2);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b0011001) begin
      failures++; $display("FAIL write_hold got=%b/%b exp=10/0011001", bus1.an, bus1.sseg);
    end
    step();
    checks++;
    if (bus1.an !== 2'b01 || bus1.sseg !== 7'b0010010) begin
      failures++; $display("FAIL write_port1 got=%b/%b exp=01/0010010", bus1.an, bus1.sseg);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b0010000) begin
      failures++; $display("FAIL write_redisplay got=%b/%b exp=10/0010000", bus1.an, bus1.sseg);
    end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] exp_an;
    bus1.readAddr = {3'd2, 3'd1};
    do_reset();
    for (int s = 1; s <= 24; s++) begin
      step();
      if (s >= 4) begin
        checks++;
        if ($countones(~bus1.an) != 1) begin
          failures++; $display("FAIL scan_onehot step=%0d got=%b exp=one_low", s, bus1.an);
        end
      end
      if (s % 4 == 0) begin
        exp_an = ((s / 4) % 2 == 1) ? 2'b10 : 2'b01;
        checks++;
        if (bus1.an !== exp_an) begin
          failures++; $display("FAIL scan_seq step=%0d got=%b exp=%b", s, bus1.an, exp_an);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [3:0] exp_an [5];
    logic [6:0] exp_sg [5];
    exp_an[0] = 4'b1110; exp_sg[0] = 7'b1111000;
    exp_an[1] = 4'b1101; exp_sg[1] = 7'b0001000;
    exp_an[2] = 4'b1011; exp_sg[2] = 7'b1000000;
    exp_an[3] = 4'b0111; exp_sg[3] = 7'b1000000;
    exp_an[4] = 4'b1110; exp_sg[4] = 7'b1111000;
    bus2.readAddr = {3'd0, 3'd5};
    do_reset();
    bus2.rwrite = 1'b0; bus2.writeAddr1 = 3'd5; bus2.data = 8'hA7;
    step();
    bus2.rwrite = 1'b1;
    steps(3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) steps(4);
      checks++;
      if (bus2.an !== exp_an[i] || bus2.sseg !== exp_sg[i]) begin
        failures++; $display("FAIL wide_slot%0d got=%b/%b exp=%b/%b", i, bus2.an, bus2.sseg, exp_an[i], exp_sg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bus1.readAddr = {3'd2, 3'd3};
    bus1.rwrite = 1'b0; bus1.writeAddr1 = 3'd3; bus1.data = 4'd9;
    rst = 1'b1;
    step();
    checks++;
    if (bus1.an !== 2'b11 || bus1.sseg !== 7'h7F) begin
      failures++; $display("FAIL rstwr_blank got=%b/%b exp=11/1111111", bus1.an, bus1.sseg);
    end
    step();
    rst = 1'b0;
    bus1.rwrite = 1'b1;
    steps(4);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b0110000) begin
      failures++; $display("FAIL rstwr_reg3 got=%b/%b exp=10/0110000", bus1.an, bus1.sseg);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b01 || bus1.sseg !== 7'b0100100) begin
      failures++; $display("FAIL rstwr_port1 got=%b/%b exp=01/0100100", bus1.an, bus1.sseg);
    end
  endtask

  task automatic test_tick_write();
    logic [6:0] exp_first;
`ifdef RFSS_WR_BYPASS_EN
    exp_first = 7'b0000010;
`else
    exp_first = 7'b1111001;
`endif
    bus1.readAddr = {3'd2, 3'd1};
    do_reset();
    steps(3);
    bus1.rwrite = 1'b0; bus1.writeAddr1 = 3'd1; bus1.data = 4'd6;
    step();
    bus1.rwrite = 1'b1;
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== exp_first) begin
      failures++; $display("FAIL tickwr_coincident got=%b/%b exp=10/%b", bus1.an, bus1.sseg, exp_first);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b01 || bus1.sseg !== 7'b0100100) begin
      failures++; $display("FAIL tickwr_port1 got=%b/%b exp=01/0100100", bus1.an, bus1.sseg);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b0000010) begin
      failures++; $display("FAIL tickwr_next got=%b/%b exp=10/0000010", bus1.an, bus1.sseg);
    end
  endtask

  task automatic test_same_addr();
    bus1.readAddr = {3'd7, 3'd7};
    do_reset();
    steps(4);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b1111000) begin
      failures++; $display("FAIL same_port0 got=%b/%b exp=10/1111000", bus1.an, bus1.sseg);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b01 || bus1.sseg !== 7'b1111000) begin
      failures++; $display("FAIL same_port1 got=%b/%b exp=01/1111000", bus1.an, bus1.sseg);
    end
    do_reset();
    bus1.rwrite = 1'b0; bus1.writeAddr1 = 3'd7; bus1.data = 4'hC;
    step();
    bus1.data = 4'hE;
    step();
    bus1.rwrite = 1'b1;
    steps(2);
    checks++;
    if (bus1.an !== 2'b10 || bus1.sseg !== 7'b0000110) begin
      failures++; $display("FAIL rewrite_port0 got=%b/%b exp=10/0000110", bus1.an, bus1.sseg);
    end
    steps(4);
    checks++;
    if (bus1.an !== 2'b01 || bus1.sseg !== 7'b0000110) begin
      failures++; $display("FAIL rewrite_port1 got=%b/%b exp=01/0000110", bus1.an, bus1.sseg);
    end
  endtask

  initial begin
    bus1.readAddr = '0; bus1.writeAddr1 = '0; bus1.data = '0; bus1.rwrite = 1'b1;
    bus2.readAddr = '0; bus2.writeAddr1 = '0; bus2.data = '0; bus2.rwrite = 1'b1;
    test_reset();
    test_write();
    test_scan_wrap();
    test_wide();
    test_reset_mid_write();
    test_tick_write();
    test_same_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
